// File: rtl/apb_slave_ctrl.sv
// APB4 slave front-end: terminates APB and forwards each in-range access to a
// backend as a registered one-cycle request, with decode-error and timeout responses.
module apb_slave_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0000_1000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    req,
  output logic                    req_write,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rsp_error
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [STRB_WIDTH-1:0] req_strb_q, req_strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // One extra bit so BASE_ADDR+ADDR_SPAN at the top of the map does not wrap.
  logic [ADDR_WIDTH:0]   paddr_ext, base_ext, limit_ext;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] addr_offset;
  logic [STRB_WIDTH-1:0] strb_fwd;
  logic                  setup_phase;
  logic                  pready_int;

  assign paddr_ext   = {1'b0, PADDR};
  assign base_ext    = {1'b0, BASE_ADDR};
  assign limit_ext   = base_ext + {1'b0, ADDR_SPAN};
  assign in_range    = (paddr_ext >= base_ext) && (paddr_ext < limit_ext);
  assign addr_offset = PADDR - BASE_ADDR;
  assign setup_phase = PSEL && !PENABLE;

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign strb_fwd[gi] = PSTRB[gi] & PWRITE;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = 1'b0;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_strb_d  = req_strb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          req_write_d = PWRITE;
          req_addr_d  = addr_offset;
          req_wdata_d = PWDATA;
          req_strb_d  = strb_fwd;
          rdata_d     = '0;
          err_d       = !in_range;
          if (in_range) begin
            req_d   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = ST_WAIT;
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (rsp_valid) begin
          // A response arriving on the timeout cycle takes priority over the timeout.
          rdata_d = req_write_q ? '0 : rsp_rdata;
          err_d   = rsp_error;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_VAL)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (!PSEL || PENABLE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_strb_q  <= req_strb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign pready_int = (state_q == ST_DONE) && PSEL && PENABLE;
  assign PREADY     = pready_int;
  assign PSLVERR    = pready_int && err_q;
  assign PRDATA     = (pready_int && !PWRITE && !err_q) ? rdata_q : '0;

  assign req       = req_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_strb  = req_strb_q;

endmodule

// File: doc/apb_slave_ctrl.md
Name: apb_slave_ctrl

Overview:
- Parametrised APB4 slave front-end. Terminates the APB protocol and drives a registered request/response handshake into a peripheral backend.
- Successor to the combinational APB slave wrapper. Adds wait-state handling, address-range decode with error response, PSTRB forwarding, and a programmable response timeout.
- Sits between the AHB-to-APB bridge and each peripheral register block.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8.
- ADDR_WIDTH, 32, PADDR width.
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave.
- ADDR_SPAN, 32'h0000_1000, decoded region size in bytes. Valid range is BASE_ADDR <= PADDR < BASE_ADDR+ADDR_SPAN.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before an error response is forced. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid only with PREADY.
- req  out  1  one-cycle request pulse to the backend.
- req_write  out  1  latched PWRITE.
- req_addr  out  ADDR_WIDTH  latched PADDR-BASE_ADDR (offset).
- req_wdata  out  DATA_WIDTH  latched PWDATA.
- req_strb  out  DATA_WIDTH/8  latched PSTRB; forced 0 on reads.
- rsp_valid  in  1  backend completion; single-cycle pulse.
- rsp_rdata  in  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_error  in  1  backend error, valid with rsp_valid.

Behaviour:
- Reset: while PRESET=1 at a clock edge:
  - FSM goes to IDLE and the timeout counter clears.
  - All req_* outputs go to 0; the internal rdata/err latches clear to 0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset mid-transfer aborts the transfer; no response is given.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On the setup phase (PSEL=1, PENABLE=0), latch PWRITE, PADDR offset, PWDATA and PSTRB into the req_* registers.
  - If the address is in range: req=1 on the next cycle (one cycle only), then go to WAIT.
  - If out of range: no req, err latch=1, go to DONE.
- WAIT:
  - The timeout counter increments each cycle from 1.
  - rsp_valid=1: latch rsp_rdata (reads only; 0 for writes) and rsp_error, then go to DONE.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: err=1, rdata=0, go to DONE.
  - rsp_valid in the same cycle as the timeout: the response wins.
- DONE:
  - PREADY = PSEL & PENABLE (combinational from state).
  - PSLVERR = err latch, gated by PREADY.
  - PRDATA = rdata latch when PREADY & !PWRITE & !err; 0 otherwise.
  - The FSM returns to IDLE on the PREADY cycle.
- Outside DONE: PREADY=0, PSLVERR=0, PRDATA=0.
- Latency:
  - Setup at cycle T0; req at T1. The earliest rsp_valid is T1, giving PREADY at T2 (one wait state minimum).
  - Decode error: PREADY at T1 (zero wait states).
- Back-to-back transfers: a setup phase in the cycle after PREADY is accepted normally, with no idle cycle required.
- Protocol abort: PSEL=0 while in WAIT or DONE sends the FSM to IDLE.
  - rsp_valid arriving while in IDLE is ignored.
  - The counter clears.
- Address arithmetic is done at ADDR_WIDTH+1 bits so BASE_ADDR+ADDR_SPAN does not wrap. Offset = PADDR-BASE_ADDR, truncated to ADDR_WIDTH.
- A write with PSTRB=0 is forwarded unchanged. The backend decides its effect.

Test Plan:
- Read, in range: PADDR=BASE+0x10, rsp_valid with rsp_rdata=32'hDEADBEEF two cycles after req. Required: req_addr=0x10, req_strb=0, PREADY high for exactly one cycle, PRDATA=DEADBEEF, PSLVERR=0.
- Write: PWDATA=32'h12345678, PSTRB=4'b0101, immediate rsp_valid. Required: req_wdata, req_strb and req_write=1 latched; PREADY at T2; PRDATA=0.
- Decode error: PADDR=BASE+ADDR_SPAN. Required: no req pulse, PREADY and PSLVERR high in the first access cycle, PRDATA=0.
- Timeout: TIMEOUT_CYCLES=4, backend silent. Required: PREADY with PSLVERR=1 exactly 4 WAIT cycles after entering WAIT. A repeat run with rsp_valid on the 4th cycle must give PSLVERR=rsp_error.
- Back-to-back plus backend error: a read then a write with no idle cycle between; the first gets rsp_error=1. Required: PSLVERR=1 on the first transfer, PSLVERR=0 on the second, two req pulses.
- Reset mid-WAIT: assert PRESET one cycle after req. Required: all outputs 0 next cycle. A late rsp_valid produces no PREADY, and the next transfer completes normally.
